ad7606_emu: RTL and testbench

AD7606_EMU -- requirements
Module: ad7606_emu

---
 rtl/ad7606_emu.sv | 100 ++++++++++
 tb/tb_ad7606_emu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ad7606_emu.sv
// ad7606_emu: behavioural AD7606 ADC emulator with convst/busy timing and a cs/rd readout of 8 channels.
// Ports: clk, rst_n (async active-low), ad_reset (sync device reset), ad_convstab (conversion start),
//        ad_cs/ad_rd (active-low read bus), ad_os (oversampling), ad_data/ad_busy/first_data (registered outputs).
module ad7606_emu #(
  parameter int CONV_CYCLES = 200,
  parameter int BUSY_DLY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad_reset,
  input  logic        ad_convstab,
  input  logic        ad_cs,
  input  logic        ad_rd,
  input  logic [2:0]  ad_os,
  output logic [15:0] ad_data,
  output logic        ad_busy,
  output logic        first_data
);
  typedef enum logic [1:0] {IDLE, DELAY, CONV} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic [2:0]  r_idx;
  logic [12:0] r_frame;
  logic [15:0] r_hold [8];
  logic        r_cnv_prev;
  logic        r_rd_prev;
  logic        w_cnv_rise;
  logic        w_rd_fall;
  logic        w_rd_rise;
  logic        w_end;
  logic [15:0] w_len;
  assign w_cnv_rise = !r_cnv_prev && ad_convstab;
  assign w_rd_fall  = r_rd_prev && !ad_rd && !ad_cs;
  assign w_rd_rise  = !r_rd_prev && ad_rd && !ad_cs;
  assign w_end      = (r_state == CONV) && (r_cnt == 16'd0);
  // os 7 is a reserved code and falls back to the base duration
  assign w_len      = (ad_os == 3'd7) ? 16'(CONV_CYCLES) : 16'(CONV_CYCLES << ad_os);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_cnv_prev <= 1'b1;
      r_rd_prev  <= 1'b1;
      ad_data    <= '0;
      ad_busy    <= 1'b0;
      first_data <= 1'b0;
      for (int k = 0; k < 8; k++) r_hold[k] <= '0;
    end else if (ad_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_cnv_prev <= 1'b1;
      r_rd_prev  <= 1'b1;
      ad_data    <= '0;
      ad_busy    <= 1'b0;
      first_data <= 1'b0;
      for (int k = 0; k < 8; k++) r_hold[k] <= '0;
    end else begin
      r_cnv_prev <= ad_convstab;
      r_rd_prev  <= ad_rd;
      case (r_state)
        IDLE:
          if (w_cnv_rise) begin
            r_state <= DELAY;
            r_cnt   <= '0;
            r_len   <= w_len;
          end
        DELAY:
          if (r_cnt == 16'(BUSY_DLY - 1)) begin
            r_state <= CONV;
            r_cnt   <= r_len - 16'd1;
            ad_busy <= 1'b1;
          end else r_cnt <= r_cnt + 16'd1;
        CONV:
          if (w_end) begin
            r_state <= IDLE;
            ad_busy <= 1'b0;
            r_frame <= r_frame + 13'd1;
            for (int k = 0; k < 8; k++) r_hold[k] <= {r_frame, 3'(k)};
          end else r_cnt <= r_cnt - 16'd1;
        default: r_state <= IDLE;
      endcase
      r_idx <= w_end ? 3'd0 : r_idx + {2'b0, w_rd_rise};
      // a read colliding with conversion end returns CH1 of the fresh frame
      if (ad_cs) begin
        ad_data    <= '0;
        first_data <= 1'b0;
      end else if (w_rd_fall) begin
        ad_data    <= w_end ? {r_frame, 3'd0} : r_hold[r_idx];
        first_data <= w_end || (r_idx == 3'd0);
      end
    end
  end
endmodule

// File: tb/tb_ad7606_emu.sv
// tb_ad7606_emu: randomized self-checking bench for ad7606_emu against a frame/read-index reference model.
module tb_ad7606_emu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ad_reset = 1'b0;
  logic        ad_convstab = 1'b0;
  logic        ad_cs = 1'b1;
  logic        ad_rd = 1'b1;
  logic [2:0]  ad_os = 3'd0;
  logic [15:0] ad_data;
  logic        ad_busy;
  logic        first_data;
  int n_chk = 0;
  int n_pass = 0;
  int m_done = 0;
  int m_idx = 0;
  ad7606_emu dut (
    .clk(clk), .rst_n(rst_n), .ad_reset(ad_reset), .ad_convstab(ad_convstab),
    .ad_cs(ad_cs), .ad_rd(ad_rd), .ad_os(ad_os),
    .ad_data(ad_data), .ad_busy(ad_busy), .first_data(first_data)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [15:0] exp_val(input int idx);
    logic [12:0] f;
    f = 13'(m_done - 1);
    return (m_done == 0) ? 16'h0000 : {f, 3'(idx)};
  endfunction
  task automatic rd_one();
    @(negedge clk);
    ad_cs = 1'b0;
    ad_rd = 1'b0;
    @(negedge clk);
    chk("rd_data", ad_data, exp_val(m_idx));
    chk("rd_first", first_data, m_idx == 0);
    ad_rd = 1'b1;
    m_idx = (m_idx + 1) % 8;
  endtask
  task automatic cs_high();
    @(negedge clk);
    ad_cs = 1'b1;
    @(negedge clk);
    chk("cs_data", ad_data, 0);
    chk("cs_first", first_data, 0);
    ad_cs = 1'b0;
  endtask
  task automatic do_conv(input logic [2:0] os, input bit pulse, input bit collide);
    int d, w, n;
    n = (os == 3'd7) ? 200 : (200 << os);
    @(negedge clk);
    ad_os = os;
    ad_convstab = 1'b0;
    repeat (2) @(negedge clk);
    ad_convstab = 1'b1;
    d = 0;
    while (d < 20) begin
      @(posedge clk);
      d++;
      @(negedge clk);
      if (ad_busy) break;
    end
    chk("busy_dly", d, 3);
    ad_os = 3'($urandom_range(0, 7));
    w = 1;
    while (w < 20000) begin
      if (w == 10) ad_convstab = 1'b0;
      if (pulse && w == 50) ad_convstab = 1'b1;
      if (pulse && w == 52) ad_convstab = 1'b0;
      if (collide && w == n) begin
        ad_cs = 1'b0;
        ad_rd = 1'b0;
      end
      @(negedge clk);
      if (!ad_busy) break;
      w++;
    end
    chk("busy_len", w, n);
    m_done++;
    m_idx = 0;
    if (collide) begin
      chk("col_data", ad_data, exp_val(0));
      chk("col_first", first_data, 1);
      ad_rd = 1'b1;
      m_idx = 1;
    end
  endtask
  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_data", ad_data, 0);
    chk("rst_busy", ad_busy, 0);
    chk("rst_first", first_data, 0);
    rd_one();
    rd_one();
    do_conv(3'd0, 0, 0);
    for (int i = 0; i < 8; i++) rd_one();
    do_conv(3'd0, 0, 0);
    for (int i = 0; i < 8; i++) rd_one();
    do_conv(3'd2, 0, 0);
    do_conv(3'd7, 0, 0);
    do_conv(3'd0, 1, 0);
    for (int i = 0; i < 10; i++) rd_one();
    do_conv(3'd0, 0, 1);
    for (int i = 0; i < 7; i++) rd_one();
    @(negedge clk);
    ad_os = 3'd0;
    ad_convstab = 1'b0;
    @(negedge clk);
    ad_convstab = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_busy_on", ad_busy, 1);
    repeat (100) @(negedge clk);
    ad_reset = 1'b1;
    ad_convstab = 1'b0;
    @(negedge clk);
    chk("ar_busy_off", ad_busy, 0);
    chk("ar_data", ad_data, 0);
    ad_reset = 1'b0;
    m_done = 0;
    m_idx = 0;
    repeat (150) @(negedge clk);
    chk("ar_discard", ad_busy, 0);
    rd_one();
    do_conv(3'd0, 0, 0);
    for (int i = 0; i < 8; i++) rd_one();
    for (int it = 0; it < 4; it++) begin
      logic [2:0] os;
      int nr;
      os = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 3));
      do_conv(os, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nr = $urandom_range(1, 12);
      for (int j = 0; j < nr; j++) begin
        if ($urandom_range(0, 3) == 0) cs_high();
        rd_one();
      end
    end
    rd_one();
    @(negedge clk);
    ad_cs = 1'b0;
    ad_rd = 1'b0;
    @(posedge clk);
    #2;
    chk("ar_pre", ad_data, exp_val(m_idx));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data", ad_data, 0);
    chk("arst_busy", ad_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ad_rd = 1'b1;
    m_done = 0;
    m_idx = 0;
    rd_one();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
